imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Instruction-side counterpart of the datapath immediate decoder: takes a template instruction word, a 32-bit immediate and an immediate-format code, and writes the immediate into that format's bit positions.
- Packed words are buffered in a small FIFO and drained over a valid/ready stream, each tagged with a word address, for loading instruction memory in test benches and boot images.
- Round-trip invariant: decoding out_instr with the same ExtOp returns in_imm whenever in_imm is representable in that format.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 16, width of out_addr.
- BASE_ADDR, 0, out_addr value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_ExtOp  input  3  000 I, 001 U, 010 S, 011 B, 100 J; other codes illegal.
- in_base  input  32  template instruction (opcode, registers, funct fields).
- in_imm  input  32  immediate value.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head when out_valid && out_ready.
- out_instr  output  32  packed instruction at FIFO head.
- out_addr  output  ADDR_W  address of the head word.
- err  output  1  sticky error flag.
- err_clr  input  1  synchronous clear of err.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, level=0, out_valid=0, in_ready=1.
  - err=0, out_addr=BASE_ADDR, out_instr=0.
- Packing (combinational on the input side):
  - Clear the format's immediate bit positions in in_base, then OR in the immediate bits.
  - I: [31:20]=imm[11:0].
  - U: [31:12]=imm[31:12].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - Illegal ExtOp: word = in_base unchanged; err set on acceptance.
- Handshake:
  - in_ready = (level != DEPTH); registered-state only, so a same-cycle pop never opens a full FIFO.
  - An accepted word is written at the clock edge; out_valid is high the next cycle when the FIFO was empty (1-cycle latency).
  - No combinational path from input to output.
  - Once out_valid is high, out_instr and out_addr are held stable until popped.
- Simultaneous push and pop: level unchanged; order preserved.
- Pop when empty: ignored. Push when full: impossible because in_ready=0.
- Addressing:
  - out_addr advances by 4 on each pop and wraps modulo 2^ADDR_W.
  - Inputs do not affect out_addr.
- err:
  - Sets on an error event; cleared by err_clr.
  - If err_clr and a new error event occur in the same cycle, err=1 (set wins).
- Reset mid-stream discards all buffered words and returns out_addr to BASE_ADDR.

Optional Feature:
- Macro IMM_PACKER_RANGE_CHECK_EN.
- When defined, an accepted request also sets err if the immediate is not representable in its format:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
- A failing word is still packed (truncated) and enqueued.
- When undefined, err is set only by an illegal ExtOp.

Test Plan:
- I: base 0x00000093, imm 0xFFFFFFFF -> out_instr 0xFFF00093, out_addr BASE_ADDR, out_valid one cycle after accept.
- S/B/J/U:
  - S: base 0x0020A023, imm 4 -> 0x0020A223.
  - B: base 0x00000063, imm 0xFFFFFFFC -> 0xFE000EE3.
  - J: base 0x0000006F, imm 8 -> 0x0080006F.
  - U: base 0x000002B7, imm 0x12345000 -> 0x123452B7.
  - Each word is fed back through the decoder with its ExtOp and must return in_imm.
- Backpressure, DEPTH=4, out_ready=0:
  - Five requests -> first four accepted, level=4, in_ready=0, fifth held.
  - Raise out_ready -> words drain in order with addresses 0,4,8,12,16.
  - Push+pop in the same cycle keeps level constant.
- Illegal ExtOp 3'b111, base 0x12345678 -> out_instr 0x12345678, err=1.
  - err_clr alone -> err=0.
  - err_clr with a new illegal request in the same cycle -> err=1.
- Range check, I-type imm 0x00000800 -> err=1 with IMM_PACKER_RANGE_CHECK_EN defined, err=0 without; out_instr [31:20]=0x800 in both builds.
- rst_n low asynchronously with 3 words buffered:
  - Immediately: out_valid=0, level=0.
  - After release: out_addr=BASE_ADDR; the next request is emitted at BASE_ADDR.

Source files
------------

// File: rtl/imm_packer.sv
// -----------------------------------------------------------------------------
// imm_packer
//
// Purpose:
//    Inserts a 32-bit immediate into the bit positions of a RISC-V style
//    instruction format (I/U/S/B/J). The result is built from a template word,
//    buffered in a small FIFO and streamed out over valid/ready. Each output
//    word carries a word address that advances by 4 per word, so the stream
//    can be used to load instruction memory.
//
// Ports:
//    clk        clock, all state changes on the rising edge
//    rst_n      asynchronous active-low reset
//    in_valid   request valid
//    in_ready   request accepted when in_valid && in_ready
//    in_ExtOp   format code: 000 I, 001 U, 010 S, 011 B, 100 J, others illegal
//    in_base    template instruction word
//    in_imm     immediate value to insert
//    out_valid  FIFO head valid
//    out_ready  consumer takes the head when out_valid && out_ready
//    out_instr  packed instruction at the FIFO head (0 when empty)
//    out_addr   address of the head word
//    err        sticky error flag
//    err_clr    synchronous clear of err (a same-cycle error event wins)
//    level      FIFO occupancy
//
// Optional feature:
//    IMM_PACKER_RANGE_CHECK_EN - when defined, an accepted immediate that is
//    not representable in its format also sets err. The word is still packed
//    (truncated) and enqueued.
// -----------------------------------------------------------------------------
module imm_packer #(
   parameter int          DEPTH     = 4,
   parameter int          ADDR_W    = 16,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_ExtOp,
   input  logic [31:0]                in_base,
   input  logic [31:0]                in_imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [ADDR_W-1:0]          out_addr,
   output logic                       err,
   input  logic                       err_clr,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   localparam logic [2:0] OP_I = 3'b000;
   localparam logic [2:0] OP_U = 3'b001;
   localparam logic [2:0] OP_S = 3'b010;
   localparam logic [2:0] OP_B = 3'b011;
   localparam logic [2:0] OP_J = 3'b100;

   logic [31:0]       mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [LW-1:0]     level_reg;
   logic [LW-1:0]     level_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              err_reg;
   logic              err_next;

   logic [31:0]       imm_mask;
   logic [31:0]       imm_bits;
   logic [31:0]       packed_word;
   logic              illegal_op;
   logic              err_event;
   logic              push;
   logic              pop;

   // -------------------------------------------------------------------------
   // Packing: each format names which template bits belong to the immediate
   // (mask) and where the immediate bits land (bits). Illegal codes leave the
   // template untouched.
   // -------------------------------------------------------------------------
   always_comb begin
      imm_mask   = '0;
      imm_bits   = '0;
      illegal_op = 1'b0;
      case (in_ExtOp)
         OP_I: begin
            imm_mask = 32'hFFF0_0000;
            imm_bits = {in_imm[11:0], 20'b0};
         end
         OP_U: begin
            imm_mask = 32'hFFFF_F000;
            imm_bits = {in_imm[31:12], 12'b0};
         end
         OP_S: begin
            imm_mask = 32'hFE00_0F80;
            imm_bits = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
         end
         OP_B: begin
            imm_mask = 32'hFE00_0F80;
            imm_bits = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
         end
         OP_J: begin
            imm_mask = 32'hFFFF_F000;
            imm_bits = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
         end
         default: begin
            illegal_op = 1'b1;
         end
      endcase
   end

   assign packed_word = (in_base & ~imm_mask) | imm_bits;

`ifdef IMM_PACKER_RANGE_CHECK_EN
   // An immediate fits when every bit above the format's top bit matches the
   // sign bit, and (for branch/jump) the implicit zero LSB really is zero.
   logic range_bad;

   always_comb begin
      range_bad = 1'b0;
      case (in_ExtOp)
         OP_I, OP_S: range_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         OP_B:       range_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
         OP_J:       range_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
         OP_U:       range_bad = (in_imm[11:0] != 12'h000);
         default:    range_bad = 1'b0;
      endcase
   end

   assign err_event = illegal_op || range_bad;
`else
   assign err_event = illegal_op;
`endif

   // -------------------------------------------------------------------------
   // Handshake. in_ready depends on registered occupancy only, so a pop in the
   // same cycle does not let a full FIFO accept.
   // -------------------------------------------------------------------------
   assign in_ready  = (level_reg != FULL_LEVEL);
   assign out_valid = (level_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // Set has priority over clear so a same-cycle error is never lost.
   always_comb begin
      err_next = err_reg;
      if (push && err_event) begin
         err_next = 1'b1;
      end else if (err_clr) begin
         err_next = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         addr_reg   <= ADDR_W'(BASE_ADDR);
         err_reg    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
            addr_reg   <= addr_reg + ADDR_W'(4);
         end
         level_reg <= level_next;
         err_reg   <= err_next;
      end
   end

   // Storage needs no reset: the read side is gated by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= packed_word;
      end
   end

   assign out_instr = out_valid ? mem[rd_ptr_reg] : 32'h0000_0000;
   assign out_addr  = addr_reg;
   assign err       = err_reg;
   assign level     = level_reg;

endmodule

// File: tb/tb_imm_packer.sv
module tb_imm_packer;

   localparam int DEPTH = 4;
   localparam int ADDR_W = 16;
   localparam int unsigned BASE = 0;
`ifdef IMM_PACKER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_ExtOp = 3'd0;
   logic [31:0] in_base = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [15:0] out_addr;
   logic        err;
   logic        err_clr = 1'b0;
   logic [2:0]  level;

   int n_cmp = 0;
   int n_fail = 0;

   imm_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ExtOp(in_ExtOp), .in_base(in_base), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr),
      .err(err), .err_clr(err_clr), .level(level)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1);
   end

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [31:0] instr;
      logic [2:0]  op;
      logic [31:0] imm;
   } ent_t;

   ent_t sb[$];
   logic [15:0] m_addr = 16'(BASE);
   bit          m_err = 1'b0;

   // Immediate bit feeding instruction bit i, or -1 when i is not an imm bit.
   function automatic int immbit(logic [2:0] op, int i);
      case (op)
         3'd0: return (i >= 20) ? i - 20 : -1;
         3'd1: return (i >= 12) ? i : -1;
         3'd2: begin
            if (i >= 25) return i - 20;
            if (i >= 7 && i <= 11) return i - 7;
            return -1;
         end
         3'd3: begin
            if (i == 31) return 12;
            if (i >= 25) return i - 20;
            if (i >= 8 && i <= 11) return i - 7;
            if (i == 7) return 11;
            return -1;
         end
         3'd4: begin
            if (i == 31) return 20;
            if (i >= 21) return i - 20;
            if (i == 20) return 11;
            if (i >= 12) return i;
            return -1;
         end
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] model_pack(logic [2:0] op, logic [31:0] base, logic [31:0] imm);
      logic [31:0] r;
      r = base;
      for (int i = 0; i < 32; i++) begin
         int b;
         b = immbit(op, i);
         if (b >= 0) r[i] = imm[b];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_decode(logic [2:0] op, logic [31:0] w);
      case (op)
         3'd0: return {{20{w[31]}}, w[31:20]};
         3'd1: return {w[31:12], 12'b0};
         3'd2: return {{20{w[31]}}, w[31:25], w[11:7]};
         3'd3: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      endcase
   endfunction

   function automatic bit representable(logic [2:0] op, logic [31:0] imm);
      int s;
      s = signed'(imm);
      case (op)
         3'd0, 3'd2: return (s >= -2048) && (s <= 2047);
         3'd3:       return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
         3'd4:       return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
         3'd1:       return imm[11:0] == 12'h000;
         default:    return 1'b1;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // One clock cycle: compare DUT state to the model, clock, update model.
   task automatic cycle(output bit accepted);
      bit push, pop, ev, new_err;
      ent_t e;
      check("level", 32'(level), 32'(sb.size()));
      check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("err", 32'(err), 32'(m_err));
      if (sb.size() > 0) begin
         check("out_instr", out_instr, sb[0].instr);
         check("out_addr", 32'(out_addr), 32'(m_addr));
      end
      push = in_valid && (sb.size() < DEPTH);
      pop  = out_ready && (sb.size() > 0);
      ev   = (in_ExtOp > 3'd4) || (RC && !representable(in_ExtOp, in_imm));
      new_err = (push && ev) ? 1'b1 : (err_clr ? 1'b0 : m_err);
      e.instr = model_pack(in_ExtOp, in_base, in_imm);
      e.op    = in_ExtOp;
      e.imm   = in_imm;
      @(posedge clk);
      #1;
      if (pop) begin
         $display("pop  addr=0x%04h instr=0x%08h op=%0d imm=0x%08h", m_addr, sb[0].instr, sb[0].op, sb[0].imm);
         if (sb[0].op <= 3'd4 && representable(sb[0].op, sb[0].imm))
            check("roundtrip", model_decode(sb[0].op, sb[0].instr), sb[0].imm);
         void'(sb.pop_front());
         m_addr = m_addr + 16'd4;
      end
      if (push) sb.push_back(e);
      m_err = new_err;
      accepted = push;
   endtask

   task automatic drain();
      bit a;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 3 * DEPTH && sb.size() > 0; t++) cycle(a);
      out_ready = 1'b0;
      check("drain_empty", 32'(level), 32'd0);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [2:0]  op;
      logic [31:0] base;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   vec_t vecs[11];

   initial begin
      bit a;
      int k;

      vecs[0]  = '{3'd0, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
      vecs[1]  = '{3'd2, 32'h0020_A023, 32'h0000_0004, 32'h0020_A223, 1'b0};
      vecs[2]  = '{3'd3, 32'h0000_0063, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
      vecs[3]  = '{3'd4, 32'h0000_006F, 32'h0000_0008, 32'h0080_006F, 1'b0};
      vecs[4]  = '{3'd1, 32'h0000_02B7, 32'h1234_5000, 32'h1234_52B7, 1'b0};
      vecs[5]  = '{3'd7, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
      vecs[6]  = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1};
      vecs[7]  = '{3'd0, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, RC};
      vecs[8]  = '{3'd4, 32'h0000_00EF, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0};
      vecs[9]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h000F_FFFF, 1'b0};
      vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0000, 32'h01FF_F07F, 1'b0};

      // ---- reset state
      #23;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_addr", 32'(out_addr), 32'(BASE));
      check("rst_out_instr", out_instr, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ---- backpressure: five requests, four fit
      out_ready = 1'b0;
      k = 0;
      for (int t = 0; t < 8; t++) begin
         in_valid = 1'b1;
         in_ExtOp = 3'd0;
         in_base  = 32'h0000_0013;
         in_imm   = 32'(k + 1);
         cycle(a);
         if (a) k++;
      end
      check("bp_accepted", 32'(k), 32'd4);
      check("bp_level_full", 32'(level), 32'd4);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      cycle(a);                         // pop only, FIFO was full
      check("bp_level_after_pop", 32'(level), 32'd3);
      cycle(a);                         // fifth word pushed while popping
      check("bp_push_pop_level", 32'(level), 32'd3);
      drain();
      check("bp_addr_after_five", 32'(out_addr), 32'(BASE + 20));

      // ---- error set / clear priority
      in_valid = 1'b1; in_ExtOp = 3'd7; in_base = 32'h1234_5678; in_imm = 32'h0;
      cycle(a);
      check("err_set", 32'(err), 32'd1);
      err_clr = 1'b1;
      cycle(a);
      check("err_set_wins", 32'(err), 32'd1);
      in_valid = 1'b0;
      cycle(a);
      err_clr = 1'b0;
      check("err_clr_alone", 32'(err), 32'd0);
      drain();

      // ---- table vectors, one at a time into an empty FIFO
      foreach (vecs[i]) begin
         in_valid = 1'b1;
         in_ExtOp = vecs[i].op;
         in_base  = vecs[i].base;
         in_imm   = vecs[i].imm;
         cycle(a);
         in_valid = 1'b0;
         $display("vec %0d op=%0d base=0x%08h imm=0x%08h -> instr=0x%08h err=%0b", i, vecs[i].op,
                  vecs[i].base, vecs[i].imm, out_instr, err);
         check("vec_valid", 32'(out_valid), 32'd1);
         check("vec_instr", out_instr, vecs[i].exp_instr);
         check("vec_err", 32'(err), 32'(vecs[i].exp_err));
         out_ready = 1'b1;
         err_clr = 1'b1;
         cycle(a);
         out_ready = 1'b0;
         err_clr = 1'b0;
         check("vec_err_cleared", 32'(err), 32'd0);
      end

      // ---- asynchronous reset with three buffered words
      for (int t = 0; t < 3; t++) begin
         in_valid = 1'b1; in_ExtOp = 3'd1; in_base = 32'h37; in_imm = 32'(t) << 12;
         cycle(a);
      end
      in_valid = 1'b0;
      check("pre_rst_level", 32'(level), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_level", 32'(level), 32'd0);
      sb.delete();
      m_addr = 16'(BASE);
      m_err = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_addr", 32'(out_addr), 32'(BASE));
      in_valid = 1'b1; in_ExtOp = 3'd0; in_base = 32'h93; in_imm = 32'h7FF;
      cycle(a);
      in_valid = 1'b0;
      check("post_rst_first_addr", 32'(out_addr), 32'(BASE));
      check("post_rst_first_instr", out_instr, 32'h7FF0_0093);
      drain();

      // ---- randomized traffic against the model
      for (int t = 0; t < 600; t++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 7) == 0);
         in_ExtOp  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         in_base   = $urandom;
         case ($urandom_range(0, 3))
            0: in_imm = $urandom;
            1: in_imm = {{20{1'b0}}, 12'($urandom)} ^ ({32{$urandom_range(0, 1) == 1}} & 32'hFFFF_F000);
            2: in_imm = 32'(signed'(13'($urandom))) & 32'hFFFF_FFFE;
            default: in_imm = $urandom & 32'hFFFF_F000;
         endcase
         cycle(a);
      end
      err_clr = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
